hdmi_tmds_decoder: RTL and testbench

//  Receive-side TMDS channel decoder; the inverse of the transmit-side per-channel encoder.

---
 rtl/hdmi_pkg.sv | 38 +++
 rtl/hdmi_tmds_lock_fsm.sv | 121 ++++++++++++
 rtl/hdmi_tmds_decoder.sv | 131 +++++++++++++
 tb/tb_hdmi_tmds_decoder.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
// Shared TMDS definitions: control tokens, lock FSM state encoding and the
// encoder's transition-minimisation stage (also used by the transmit encoder).
package hdmi_pkg;

   localparam logic [9:0] TOK_C00 = 10'h354;
   localparam logic [9:0] TOK_C01 = 10'h0AB;
   localparam logic [9:0] TOK_C10 = 10'h154;
   localparam logic [9:0] TOK_C11 = 10'h2AB;

   typedef enum logic [1:0] {
      ST_SEARCH    = 2'd0,
      ST_SLIP_WAIT = 2'd1,
      ST_LOCKED    = 2'd2
   } lock_state_e;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
      return n;
   endfunction

   // Returns {q_m[8], q_m[7:0]}; q_m[8]=1 selects the XOR chain.
   function automatic logic [8:0] tmds_transition_min(input logic [7:0] d);
      logic [8:0] q;
      logic [3:0] n1;
      logic       use_xnor;
      n1       = popcount8(d);
      use_xnor = (n1 > 4'd4) || ((n1 == 4'd4) && !d[0]);
      q        = 9'd0;
      q[0]     = d[0];
      for (int i = 1; i < 8; i++)
         q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
      q[8] = ~use_xnor;
      return q;
   endfunction

endpackage

// File: rtl/hdmi_tmds_lock_fsm.sv
// Word-alignment lock FSM: counts control-token runs in SEARCH, requests
// bitslips on timeout, and monitors the symbol-error rate while LOCKED.
module hdmi_tmds_lock_fsm #(
   parameter int LOCK_RUN       = 8,
   parameter int SEARCH_TIMEOUT = 2048,
   parameter int SLIP_WAIT      = 16,
   parameter int ERR_WINDOW     = 1024,
   parameter int ERR_LIMIT      = 4
) (
   input  logic i_pixclk,
   input  logic i_reset,
   input  logic i_token,
   input  logic i_sym_err,
   output logic o_locked,
   output logic o_bitslip
);
   import hdmi_pkg::*;

   localparam int TMR_MAX = (SEARCH_TIMEOUT > SLIP_WAIT) ? SEARCH_TIMEOUT : SLIP_WAIT;
   localparam int TW      = $clog2(TMR_MAX + 1);
   localparam int RW      = $clog2(LOCK_RUN + 1);
   localparam int WW      = $clog2(ERR_WINDOW + 1);
   localparam int EW      = $clog2(ERR_LIMIT + 1);

   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(SEARCH_TIMEOUT - 1);
   localparam logic [TW-1:0] WAIT_LAST    = TW'(SLIP_WAIT - 1);
   localparam logic [RW-1:0] RUN_LAST     = RW'(LOCK_RUN - 1);
   localparam logic [WW-1:0] WIN_LAST     = WW'(ERR_WINDOW - 1);
   localparam logic [EW-1:0] ERR_LIM      = EW'(ERR_LIMIT);

   lock_state_e   state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [RW-1:0] run_q, run_d;
   logic [WW-1:0] win_q, win_d;
   logic [EW-1:0] errc_q, errc_d;
   logic          slip_q, slip_d;
   logic [EW-1:0] errc_sum;

   always_ff @(posedge i_pixclk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= ST_SEARCH;
         tmr_q   <= '0;
         run_q   <= '0;
         win_q   <= '0;
         errc_q  <= '0;
         slip_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         run_q   <= run_d;
         win_q   <= win_d;
         errc_q  <= errc_d;
         slip_q  <= slip_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      tmr_d    = tmr_q;
      run_d    = run_q;
      win_d    = win_q;
      errc_d   = errc_q;
      slip_d   = 1'b0;
      errc_sum = errc_q + EW'(i_sym_err);
      case (state_q)
         ST_SEARCH: begin
            if (i_token && (run_q == RUN_LAST)) begin
               state_d = ST_LOCKED;
               run_d   = '0;
               tmr_d   = '0;
               win_d   = '0;
               errc_d  = '0;
            end else begin
               run_d = i_token ? run_q + RW'(1) : '0;
               if (tmr_q == TIMEOUT_LAST) begin
                  state_d = ST_SLIP_WAIT;
                  slip_d  = 1'b1;
                  tmr_d   = '0;
                  run_d   = '0;
               end else begin
                  tmr_d = tmr_q + TW'(1);
               end
            end
         end
         ST_SLIP_WAIT: begin
            // The deserializer is realigning; symbols here are meaningless.
            if (tmr_q == WAIT_LAST) begin
               state_d = ST_SEARCH;
               tmr_d   = '0;
               run_d   = '0;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         ST_LOCKED: begin
            if (errc_sum == ERR_LIM) begin
               state_d = ST_SEARCH;
               tmr_d   = '0;
               run_d   = '0;
               win_d   = '0;
               errc_d  = '0;
            end else if (win_q == WIN_LAST) begin
               win_d  = '0;
               errc_d = '0;
            end else begin
               win_d  = win_q + WW'(1);
               errc_d = errc_sum;
            end
         end
         default: begin
            state_d = ST_SEARCH;
            tmr_d   = '0;
            run_d   = '0;
         end
      endcase
   end

   assign o_locked  = (state_q == ST_LOCKED);
   assign o_bitslip = slip_q;

endmodule

// File: rtl/hdmi_tmds_decoder.sv
// Receive-side TMDS channel decoder with lock FSM. Defining HDMI_RX_ERR_CNT_EN
// adds the o_err_cnt port with a saturating invalid-symbol counter.
module hdmi_tmds_decoder #(
   parameter int LOCK_RUN       = 8,
   parameter int SEARCH_TIMEOUT = 2048,
   parameter int SLIP_WAIT      = 16,
   parameter int ERR_WINDOW     = 1024,
   parameter int ERR_LIMIT      = 4
) (
   input  logic        i_pixclk,
   input  logic        i_reset,
   input  logic [9:0]  i_symbol,
   output logic [7:0]  o_data,
   output logic        o_de,
   output logic [1:0]  o_ctrl,
   output logic        o_sym_err,
   output logic        o_locked,
   output logic        o_bitslip
`ifdef HDMI_RX_ERR_CNT_EN
   ,
   output logic [15:0] o_err_cnt
`endif
);
   import hdmi_pkg::*;

   logic [9:0] sym_q, sym_d;
   logic [7:0] data_q, data_d;
   logic       de_q, de_d;
   logic [1:0] ctrl_q, ctrl_d;
   logic       err_q, err_d;

   logic [7:0] raw_bits;
   logic [7:0] vid_byte;
   logic       is_tok;
   logic [1:0] tok_ctrl;
   logic       needs_balance;
   logic       vid_legal;

   always_ff @(posedge i_pixclk or posedge i_reset) begin
      if (i_reset) begin
         sym_q  <= '0;
         data_q <= '0;
         de_q   <= 1'b0;
         ctrl_q <= '0;
         err_q  <= 1'b0;
      end else begin
         sym_q  <= sym_d;
         data_q <= data_d;
         de_q   <= de_d;
         ctrl_q <= ctrl_d;
         err_q  <= err_d;
      end
   end

   always_comb begin
      sym_d    = i_symbol;
      is_tok   = 1'b1;
      tok_ctrl = 2'b00;
      case (sym_q)
         TOK_C00: tok_ctrl = 2'b00;
         TOK_C01: tok_ctrl = 2'b01;
         TOK_C10: tok_ctrl = 2'b10;
         TOK_C11: tok_ctrl = 2'b11;
         default: is_tok   = 1'b0;
      endcase

      raw_bits    = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
      vid_byte    = 8'd0;
      vid_byte[0] = raw_bits[0];
      for (int i = 1; i < 8; i++)
         vid_byte[i] = sym_q[8] ? (raw_bits[i] ^ raw_bits[i-1])
                                : ~(raw_bits[i] ^ raw_bits[i-1]);

      // A code is legal only if re-encoding the byte reproduces it exactly;
      // balanced words must also carry the DC-balance bit as ~sym[8].
      needs_balance = (popcount8(raw_bits) == 4'd4) || (popcount8(vid_byte) == 4'd4);
      vid_legal     = (tmds_transition_min(vid_byte) == {sym_q[8], raw_bits}) &&
                      !(needs_balance && (sym_q[9] == sym_q[8]));

      data_d = 8'd0;
      de_d   = 1'b0;
      ctrl_d = ctrl_q;
      err_d  = 1'b0;
      if (is_tok) begin
         ctrl_d = tok_ctrl;
      end else if (vid_legal) begin
         de_d   = 1'b1;
         data_d = vid_byte;
      end else begin
         err_d = 1'b1;
      end
   end

   hdmi_tmds_lock_fsm #(
      .LOCK_RUN      (LOCK_RUN),
      .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
      .SLIP_WAIT     (SLIP_WAIT),
      .ERR_WINDOW    (ERR_WINDOW),
      .ERR_LIMIT     (ERR_LIMIT)
   ) u_lock_fsm (
      .i_pixclk (i_pixclk),
      .i_reset  (i_reset),
      .i_token  (is_tok),
      .i_sym_err(err_d),
      .o_locked (o_locked),
      .o_bitslip(o_bitslip)
   );

   assign o_data    = data_q;
   assign o_de      = de_q;
   assign o_ctrl    = ctrl_q;
   assign o_sym_err = err_q;

`ifdef HDMI_RX_ERR_CNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;

   always_ff @(posedge i_pixclk or posedge i_reset) begin
      if (i_reset) err_cnt_q <= '0;
      else         err_cnt_q <= err_cnt_d;
   end

   // Advances together with o_sym_err and sticks at all-ones.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_d && (err_cnt_q != 16'hFFFF)) err_cnt_d = err_cnt_q + 16'd1;
   end

   assign o_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_hdmi_tmds_decoder.sv
// Scoreboard bench for hdmi_tmds_decoder; with HDMI_RX_ERR_CNT_EN defined it
// also covers the saturating error counter.
`timescale 1ns/1ps
module tb_hdmi_tmds_decoder;

   localparam logic [9:0] T00 = 10'h354;
   localparam logic [9:0] T11 = 10'h2AB;
   localparam logic [9:0] SYM_A5 = 10'h163;  // legal encoding of 8'hA5
   localparam logic [9:0] BAD = 10'h00F;     // balanced word with sym[9]==sym[8]
   localparam logic [9:0] ROT = 10'h26A;     // 10'h354 rotated by 3 bits

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  sym;
   logic [7:0]  o_data;
   logic        o_de;
   logic [1:0]  o_ctrl;
   logic        o_sym_err;
   logic        o_locked;
   logic        o_bitslip;
`ifdef HDMI_RX_ERR_CNT_EN
   logic [15:0] o_err_cnt;
`endif

   hdmi_tmds_decoder dut (
      .i_pixclk (clk),
      .i_reset  (rst),
      .i_symbol (sym),
      .o_data   (o_data),
      .o_de     (o_de),
      .o_ctrl   (o_ctrl),
      .o_sym_err(o_sym_err),
      .o_locked (o_locked),
      .o_bitslip(o_bitslip)
`ifdef HDMI_RX_ERR_CNT_EN
      ,
      .o_err_cnt(o_err_cnt)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;
   int disp = 0;
   logic [1:0] cur_ctrl = 2'b00;

   typedef struct {
      int         due;
      logic [7:0] data;
      logic       de;
      logic [1:0] ctrl;
      logic       err;
      logic       cl;
      logic       lk;
   } exp_t;
   exp_t sbq[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         while (sbq.size() > 0 && sbq[0].due <= cyc) begin
            e = sbq.pop_front();
            if (e.due != cyc) begin
               chk("sb_late", cyc, e.due);
            end else begin
               chk("sb_out{de,ctrl,err,data}", {20'd0, o_de, o_ctrl, o_sym_err, o_data},
                   {20'd0, e.de, e.ctrl, e.err, e.data});
               if (e.cl) chk("sb_locked", {31'd0, o_locked}, {31'd0, e.lk});
            end
         end
      end
   end

   task automatic push_exp(input logic [7:0] d, input logic de, input logic [1:0] c,
                           input logic er, input logic cl, input logic lk);
      exp_t e;
      e.due = cyc + 2; e.data = d; e.de = de; e.ctrl = c; e.err = er; e.cl = cl; e.lk = lk;
      sbq.push_back(e);
   endtask

   task automatic send_tok(input logic [9:0] s, input logic [1:0] c, input logic cl, input logic lk);
      @(negedge clk);
      sym = s;
      cur_ctrl = c;
      push_exp(8'h00, 1'b0, c, 1'b0, cl, lk);
   endtask

   task automatic send_vid(input logic [9:0] s, input logic [7:0] d, input logic cl, input logic lk);
      @(negedge clk);
      sym = s;
      push_exp(d, 1'b1, cur_ctrl, 1'b0, cl, lk);
   endtask

   task automatic send_err(input logic [9:0] s, input logic cl, input logic lk);
      @(negedge clk);
      sym = s;
      push_exp(8'h00, 1'b0, cur_ctrl, 1'b1, cl, lk);
   endtask

   task automatic drive(input logic [9:0] s, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sym = s;
      end
   endtask

   task automatic drain();
      repeat (4) @(posedge clk);
      #2;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_data"}, {24'd0, o_data}, 32'd0);
      chk({tag, "_de"}, {31'd0, o_de}, 32'd0);
      chk({tag, "_ctrl"}, {30'd0, o_ctrl}, 32'd0);
      chk({tag, "_sym_err"}, {31'd0, o_sym_err}, 32'd0);
      chk({tag, "_locked"}, {31'd0, o_locked}, 32'd0);
      chk({tag, "_bitslip"}, {31'd0, o_bitslip}, 32'd0);
`ifdef HDMI_RX_ERR_CNT_EN
      chk({tag, "_err_cnt"}, {16'd0, o_err_cnt}, 32'd0);
`endif
   endtask

   task automatic wait_slip(input int maxc, output int at);
      at = -1;
      for (int i = 0; i < maxc; i++) begin
         @(posedge clk);
         #1;
         if (o_bitslip) begin
            at = cyc;
            break;
         end
      end
      if (at < 0) begin
         checks++;
         failures++;
         $display("FAIL slip_wait: no o_bitslip within %0d cycles", maxc);
      end
   endtask

   // Reference DVI/HDMI transmit encoder with running disparity.
   task automatic encode(input logic [7:0] b, output logic [9:0] s);
      logic [8:0] qm;
      logic       xn;
      int         n1, n1q, n0q;
      n1 = $countones(b);
      xn = (n1 > 4) || (n1 == 4 && b[0] == 1'b0);
      qm = 9'd0;
      qm[0] = b[0];
      for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ b[i]) : (qm[i-1] ^ b[i]);
      qm[8] = ~xn;
      n1q = $countones(qm[7:0]);
      n0q = 8 - n1q;
      if (disp == 0 || n1q == n0q) begin
         s = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
         disp = qm[8] ? disp + n1q - n0q : disp + n0q - n1q;
      end else if ((disp > 0 && n1q > n0q) || (disp < 0 && n0q > n1q)) begin
         s = {1'b1, qm[8], ~qm[7:0]};
         disp = disp + (qm[8] ? 2 : 0) + n0q - n1q;
      end else begin
         s = {1'b0, qm[8], qm[7:0]};
         disp = disp - (qm[8] ? 0 : 2) + n1q - n0q;
      end
   endtask

   initial begin : stim
      int p[3];
      int n, highs, at, rel, slips;
      logic prev, seen;
      logic [7:0] b;
      logic [9:0] s;
      logic e;

      rst = 1'b1;
      sym = 10'h000;
      repeat (3) @(posedge clk);
      #2;
      chk_zero("reset");
      @(negedge clk);
      rst = 1'b0;

      // Lock on eight 10'h354 tokens
      for (int k = 1; k <= 8; k++) send_tok(T00, 2'b00, 1'b1, k == 8);
      // Token 11 then video A5
      send_tok(T11, 2'b11, 1'b1, 1'b1);
      send_vid(SYM_A5, 8'hA5, 1'b1, 1'b1);
      send_tok(T00, 2'b00, 1'b1, 1'b1);

      // Four errors in one window drop lock
      for (int k = 1; k <= 4; k++) begin
         send_err(BAD, 1'b1, k < 4);
         send_tok(T00, 2'b00, 1'b1, k < 4);
      end
      for (int j = 1; j <= 7; j++) send_tok(T00, 2'b00, 1'b1, j == 7);

      // Three errors per window in two windows: stays locked
      for (int k = 1; k <= 3; k++) begin
         send_err(BAD, 1'b1, 1'b1);
         send_tok(T00, 2'b00, 1'b1, 1'b1);
      end
      drive(T00, 1100);
      for (int k = 1; k <= 3; k++) begin
         send_err(BAD, 1'b1, 1'b1);
         send_tok(T00, 2'b00, 1'b1, 1'b1);
      end
      drain();
      chk("locked_after_spread", {31'd0, o_locked}, 32'd1);

      // Encoder-generated bytes with running disparity
      disp = 0;
      for (int k = 0; k < 300; k++) begin
         b = 8'($urandom_range(0, 255));
         encode(b, s);
         e = ($countones(b) == 4) && (s[9] == s[8]);
         @(negedge clk);
         sym = s;
         push_exp(e ? 8'h00 : b, ~e, cur_ctrl, e, 1'b0, 1'b0);
      end
      drain();

      // Reset in the middle of decoding
      send_tok(T11, 2'b11, 1'b0, 1'b0);
      send_vid(SYM_A5, 8'hA5, 1'b0, 1'b0);
      drain();
      @(negedge clk);
      sym = SYM_A5;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("pre_rst_de", {31'd0, o_de}, 32'd1);
      rst = 1'b1;
      #1;
      chk_zero("rst_decode");
      @(negedge clk);
      rst = 1'b0;
      cur_ctrl = 2'b00;
      for (int k = 1; k <= 8; k++) send_tok(T00, 2'b00, 1'b1, k == 8);
      drain();

      // Rotated stream: one bitslip per SEARCH_TIMEOUT+SLIP_WAIT
      @(negedge clk);
      sym = ROT;
      n = 0;
      highs = 0;
      prev = 1'b0;
      for (int i = 0; i < 9000 && n < 3; i++) begin
         @(posedge clk);
         #1;
         if (o_bitslip) begin
            highs++;
            if (!prev) begin
               p[n] = cyc;
               n++;
            end
         end
         prev = o_bitslip;
      end
      chk("slip_count", n, 3);
      if (n == 3) begin
         chk("slip_interval_1", p[1] - p[0], 2064);
         chk("slip_interval_2", p[2] - p[1], 2064);
      end
      @(posedge clk);
      #1;
      chk("slip_width", {31'd0, o_bitslip}, 32'd0);
      chk("slip_highs", highs, 3);
      @(negedge clk);
      sym = T00;
      seen = 1'b0;
      slips = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (o_bitslip) slips++;
         seen = o_locked;
      end
      chk("relock_after_unrotate", {31'd0, seen}, 32'd1);
      chk("no_slip_while_relocking", slips, 0);

      // Reset in the middle of SLIP_WAIT
      @(negedge clk);
      sym = ROT;
      wait_slip(2300, at);
      repeat (4) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk_zero("rst_slipwait");
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      rel = cyc;
      wait_slip(2100, at);
      if (at >= 0) chk("slip_after_rst", at - rel, 2048);

`ifdef HDMI_RX_ERR_CNT_EN
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("errcnt_rst", {16'd0, o_err_cnt}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cur_ctrl = 2'b00;
      for (int k = 0; k < 10; k++) send_err(BAD, 1'b0, 1'b0);
      send_tok(T00, 2'b00, 1'b0, 1'b0);
      drain();
      chk("errcnt_10", {16'd0, o_err_cnt}, 32'd10);
      drive(BAD, 66000);
      drive(T00, 3);
      drain();
      chk("errcnt_saturate", {16'd0, o_err_cnt}, 32'h0000FFFF);
`endif

      drain();
      chk("sb_drained", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
